// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses SYNC/ADDR/D3..D0[/CSUM] byte frames into register-write strobes.
// Define CMD_CHECKSUM_EN to require and verify the trailing XOR checksum byte.
module uart_cmd_decoder #(
    parameter int CLK_HZ        = 48_000_000,
    parameter int BIT_RATE      = 9600,
    parameter int TIMEOUT_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int ADDR_W        = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);
    localparam int TIMEOUT_CYCLES = int'(64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_HZ) / 64'(BIT_RATE));
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
`ifdef CMD_CHECKSUM_EN
    localparam logic [1:0] S_CSUM  = 2'd3;
    localparam logic [1:0] S_AFTER = S_CSUM;
`else
    localparam logic [1:0] S_AFTER = S_HUNT;
`endif

    logic [1:0]        r_state;
    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_asm;
    logic [TW-1:0]     r_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_frame_err;
    logic [7:0]        r_err_count;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif
    logic w_byte;
    logic w_addr_bad;
    logic w_timeout;
    logic w_err;
    logic w_wr;

    always_comb begin
        w_byte     = rx_valid && !rx_break;
        w_addr_bad = (rx_data >> ADDR_W) != 8'd0;
        // an arriving byte always beats a timeout expiring in the same cycle
        w_timeout  = r_state != S_HUNT && !rx_valid && r_cnt == TW'(TIMEOUT_CYCLES);
`ifdef CMD_CHECKSUM_EN
        w_err = w_timeout || (w_byte && ((r_state == S_ADDR && w_addr_bad) || (r_state == S_CSUM && rx_data != r_xor)));
        w_wr  = w_byte && r_state == S_CSUM && rx_data == r_xor;
`else
        w_err = w_timeout || (w_byte && r_state == S_ADDR && w_addr_bad);
        w_wr  = w_byte && r_state == S_DATA && r_idx == 2'd3;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_HUNT;
            r_idx       <= '0;
            r_addr      <= '0;
            r_asm       <= '0;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
`ifdef CMD_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_wr_en     <= w_wr;
            r_frame_err <= w_err;
            r_cnt       <= (r_state == S_HUNT || rx_valid || w_timeout) ? '0 : r_cnt + TW'(1);
            if (w_err && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
            if (w_wr) begin
                r_wr_addr <= r_addr;
`ifdef CMD_CHECKSUM_EN
                r_wr_data <= r_asm;
`else
                r_wr_data <= {r_asm[23:0], rx_data};
`endif
            end
            if (w_err || (rx_valid && rx_break))
                r_state <= S_HUNT;
            else if (w_byte)
                case (r_state)
                    S_HUNT: r_state <= (rx_data == SYNC_BYTE) ? S_ADDR : S_HUNT;
                    S_ADDR: begin
                        r_addr  <= rx_data[ADDR_W-1:0];
                        r_idx   <= 2'd0;
                        r_state <= S_DATA;
`ifdef CMD_CHECKSUM_EN
                        r_xor   <= rx_data;
`endif
                    end
                    S_DATA: begin
                        r_asm   <= {r_asm[23:0], rx_data};
                        r_idx   <= r_idx + 2'd1;
                        r_state <= (r_idx == 2'd3) ? S_AFTER : S_DATA;
`ifdef CMD_CHECKSUM_EN
                        r_xor   <= r_xor ^ rx_data;
`endif
                    end
                    default: r_state <= S_HUNT;
                endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;
    assign err_count = r_err_count;
    assign busy      = r_state != S_HUNT;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: scoreboard bench; stimulus pushes expected writes/errors, a monitor pops them.
module tb_uart_cmd_decoder;
    localparam int AW = 4;
    localparam int T  = 4 * 10 * 96000 / 9600;
    localparam logic [55:0] GOOD = 56'hA5_03_12_34_56_78_0B;
    localparam logic [55:0] BADC = 56'hA5_03_12_34_56_78_0C;
    localparam logic [35:0] GOOD_WR = {4'h3, 32'h12345678};

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rx_valid = 1'b0;
    logic          rx_break = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          frame_err;
    logic [7:0]    err_count;
    logic          busy;

    logic [35:0] wq[$];
    logic [7:0]  eq[$];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .CLK_HZ(96000), .BIT_RATE(9600), .TIMEOUT_BYTES(4), .SYNC_BYTE(8'hA5), .ADDR_W(AW)
    ) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err),
        .err_count(err_count), .busy(busy)
    );

    task automatic chk(input string n, input logic [35:0] a, input logic [35:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (wr_en && frame_err) begin
                checks++;
                errors++;
                $display("FAIL exclusive: wr_en and frame_err both high, expected at most one");
            end
            if (wr_en) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr: unexpected write %0h/%0h, expected none", wr_addr, wr_data);
                end else
                    chk("wr", {wr_addr, wr_data}, wq.pop_front());
            end
            if (frame_err) begin
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err: unexpected frame_err (count %0d), expected none", err_count);
                end else
                    chk("err_count_at_err", {28'd0, err_count}, {28'd0, eq.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [55:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = v[8*(n-1-i) +: 8];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_break();
        rx_data  = 8'h00;
        rx_break = 1'b1;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_break = 1'b0;
    endtask

    task automatic bad();
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        eq.push_back(8'(exp_cnt));
    endtask

    task automatic drain(input string n);
        idle(4);
        chk({n, "_wq_empty"}, 36'(wq.size()), 36'd0);
        chk({n, "_eq_empty"}, 36'(eq.size()), 36'd0);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_wr_en"}, {35'd0, wr_en}, 36'd0);
        chk({n, "_frame_err"}, {35'd0, frame_err}, 36'd0);
        chk({n, "_wr_addr"}, {32'd0, wr_addr}, 36'd0);
        chk({n, "_wr_data"}, {4'd0, wr_data}, 36'd0);
        chk({n, "_err_count"}, {28'd0, err_count}, 36'd0);
        chk({n, "_busy"}, {35'd0, busy}, 36'd0);
    endtask

    initial begin
        idle(3);
        chk_zero("reset");
        resetn = 1'b1;
        idle(2);

        wq.push_back(GOOD_WR);
        send(GOOD, 7);
        drain("good");
        chk("good_busy", {35'd0, busy}, 36'd0);

`ifdef CMD_CHECKSUM_EN
        bad();
`else
        wq.push_back(GOOD_WR);
`endif
        send(BADC, 7);
        idle(2);
        wq.push_back(GOOD_WR);
        send(GOOD, 7);
        drain("badcsum");
        chk("badcsum_count", {28'd0, err_count}, 36'(exp_cnt));

        send(56'h00_FF_5A, 3);
        wq.push_back(GOOD_WR);
        send(GOOD, 7);
        drain("junk");
        chk("junk_count", {28'd0, err_count}, 36'(exp_cnt));

        bad();
        send(56'hA5_13, 2);
        idle(2);
        send(56'hA5_03_12, 3);
        idle(T);
        chk("timeout_not_yet_busy", {35'd0, busy}, 36'd1);
        bad();
        drain("timeout");
        chk("timeout_busy", {35'd0, busy}, 36'd0);
        chk("timeout_count", {28'd0, err_count}, 36'(exp_cnt));

        send(56'hA5_03_12, 3);
        idle(T);
        wq.push_back(GOOD_WR);
        send(56'h34_56_78_0B, 4);
        drain("byte_wins");

        send(56'hA5_03, 2);
        idle(T + 1);
        bad();
        drain("late_byte");

        send(56'hA5_03_12, 3);
        send_break();
        idle(1);
        chk("break_busy", {35'd0, busy}, 36'd0);
        drain("break");
        wq.push_back(GOOD_WR);
        send(GOOD, 7);
        drain("after_break");

        while (exp_cnt < 255) begin
            bad();
            send(56'hA5_13, 2);
        end
        bad();
        send(56'hA5_13, 2);
        drain("saturate");
        chk("saturate_count", {28'd0, err_count}, 36'd255);

        send(56'hA5_03_12_34, 4);
        resetn = 1'b0;
        idle(1);
        exp_cnt = 0;
        chk_zero("midreset");
        resetn = 1'b1;
        drain("midreset");
        chk("midreset_busy", {35'd0, busy}, 36'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
